// File: rtl/reg_rename_ckpt_if.sv
// Rename-stage bus: decode offer, registered rename result, and the
// writeback / commit / branch-resolution feedback paths.
interface reg_rename_ckpt_if #(
    parameter int AW = 5,
    parameter int PW = 6,
    parameter int CW = 2
);
    logic          ren_valid, ren_ready;
    logic [AW-1:0] ren_rs, ren_rt, ren_rw;
    logic          ren_uses_rw, ren_is_branch;

    logic          out_valid;
    logic [PW-1:0] out_rs_phys, out_rt_phys, out_rw_phys, out_old_phys;
    logic          out_rs_busy, out_rt_busy;
    logic [CW-1:0] out_ckpt_id;

    logic          wb_valid;
    logic [PW-1:0] wb_phys;
    logic          commit_valid;
    logic [PW-1:0] commit_old_phys;
    logic          br_valid, br_mispredict;

    logic [PW:0]   fl_count;
    logic [CW:0]   ckpt_count;

    modport master (
        output ren_valid, ren_rs, ren_rt, ren_rw, ren_uses_rw, ren_is_branch,
        output wb_valid, wb_phys, commit_valid, commit_old_phys, br_valid, br_mispredict,
        input  ren_ready, out_valid, out_rs_phys, out_rt_phys, out_rw_phys, out_old_phys,
        input  out_rs_busy, out_rt_busy, out_ckpt_id, fl_count, ckpt_count
    );

    modport slave (
        input  ren_valid, ren_rs, ren_rt, ren_rw, ren_uses_rw, ren_is_branch,
        input  wb_valid, wb_phys, commit_valid, commit_old_phys, br_valid, br_mispredict,
        output ren_ready, out_valid, out_rs_phys, out_rt_phys, out_rw_phys, out_old_phys,
        output out_rs_busy, out_rt_busy, out_ckpt_id, fl_count, ckpt_count
    );
endinterface

// File: rtl/reg_rename_ckpt.sv
// Register rename: RMT, circular free list and busy table, with in-order branch
// checkpoints (RMT + free-list head snapshots) for single-cycle mispredict recovery.
module reg_rename_ckpt #(
    parameter int NUM_ARCH_REGS = 32,
    parameter int NUM_PHYS_REGS = 64,
    parameter int NUM_CKPT      = 4
) (
    input logic              clk,
    input logic              rst,
    reg_rename_ckpt_if.slave bus
);
    localparam int PW    = $clog2(NUM_PHYS_REGS);
    localparam int CW    = $clog2(NUM_CKPT);
    localparam int NFREE = NUM_PHYS_REGS - NUM_ARCH_REGS;

    typedef logic [PW-1:0] ptag_t;

    ptag_t                    rmt_q    [NUM_ARCH_REGS];
    ptag_t                    rmt_post [NUM_ARCH_REGS];
    logic [NUM_PHYS_REGS-1:0] busy_q;
    ptag_t                    fl_q     [NUM_PHYS_REGS];
    logic [PW:0]              head_q, head_d, tail_q, fl_cnt;
    ptag_t                    ck_rmt_q [NUM_CKPT][NUM_ARCH_REGS];
    logic [PW:0]              ck_head_q[NUM_CKPT];
    logic [CW-1:0]            ckh_q, ckt_q;
    logic [CW:0]              ckc_q;

    logic          out_valid_q, out_rs_busy_q, out_rt_busy_q;
    ptag_t         out_rs_q, out_rt_q, out_rw_q, out_old_q;
    logic [CW-1:0] out_ckpt_q;

    logic  ready, dest, fire, mispred, resolve, commit_push, ckpt_fire;
    logic  rs_busy, rt_busy;
    ptag_t alloc_tag, rs_tag, rt_tag;

    always_comb begin
        fl_cnt      = tail_q - head_q;
        dest        = bus.ren_uses_rw && (bus.ren_rw != '0);
        ready       = !rst && !(bus.br_valid && bus.br_mispredict)
                      && (fl_cnt != '0 || !dest)
                      && (ckc_q != (CW+1)'(NUM_CKPT) || !bus.ren_is_branch);
        fire        = bus.ren_valid && ready;
        ckpt_fire   = fire && bus.ren_is_branch;
        mispred     = bus.br_valid && bus.br_mispredict && (ckc_q != '0);
        resolve     = bus.br_valid && !bus.br_mispredict && (ckc_q != '0);
        commit_push = bus.commit_valid && (bus.commit_old_phys != '0);
        alloc_tag   = fl_q[head_q[PW-1:0]];
        head_d      = head_q + (PW+1)'(fire && dest);
        // Sources see the pre-rename map; a same-cycle writeback already clears busy.
        rs_tag      = rmt_q[bus.ren_rs];
        rt_tag      = rmt_q[bus.ren_rt];
        rs_busy     = busy_q[rs_tag] && !(bus.wb_valid && bus.wb_phys == rs_tag) && (rs_tag != '0);
        rt_busy     = busy_q[rt_tag] && !(bus.wb_valid && bus.wb_phys == rt_tag) && (rt_tag != '0);
        for (int i = 0; i < NUM_ARCH_REGS; i++) rmt_post[i] = rmt_q[i];
        if (fire && dest) rmt_post[bus.ren_rw] = alloc_tag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) rmt_q[i] <= ptag_t'(i);
            for (int i = 0; i < NUM_PHYS_REGS; i++) fl_q[i] <= ptag_t'(NUM_ARCH_REGS + i);
            busy_q        <= '0;
            head_q        <= '0;
            tail_q        <= (PW+1)'(NFREE);
            ckh_q         <= '0;
            ckt_q         <= '0;
            ckc_q         <= '0;
            out_valid_q   <= 1'b0;
            out_rs_q      <= '0;
            out_rt_q      <= '0;
            out_rw_q      <= '0;
            out_old_q     <= '0;
            out_rs_busy_q <= 1'b0;
            out_rt_busy_q <= 1'b0;
            out_ckpt_q    <= '0;
        end else begin
            out_valid_q   <= fire;
            out_rs_q      <= fire ? rs_tag : '0;
            out_rt_q      <= fire ? rt_tag : '0;
            out_rw_q      <= (fire && dest) ? alloc_tag : '0;
            out_old_q     <= (fire && dest) ? rmt_q[bus.ren_rw] : '0;
            out_rs_busy_q <= fire && rs_busy;
            out_rt_busy_q <= fire && rt_busy;
            out_ckpt_q    <= ckpt_fire ? ckt_q : '0;

            if (commit_push) begin
                fl_q[tail_q[PW-1:0]] <= bus.commit_old_phys;
                tail_q               <= tail_q + (PW+1)'(1);
            end
            // Allocation is ordered after writeback so a same-tag collision stays busy.
            if (bus.wb_valid) busy_q[bus.wb_phys] <= 1'b0;
            if (fire && dest) busy_q[alloc_tag] <= 1'b1;

            if (mispred) begin
                rmt_q  <= ck_rmt_q[ckh_q];
                head_q <= ck_head_q[ckh_q];
                ckh_q  <= ckt_q;
                ckc_q  <= '0;
            end else begin
                rmt_q  <= rmt_post;
                head_q <= head_d;
                ckh_q  <= ckh_q + CW'(resolve);
                ckc_q  <= ckc_q + (CW+1)'(ckpt_fire) - (CW+1)'(resolve);
                if (ckpt_fire) ckt_q <= ckt_q + CW'(1);
            end
            if (ckpt_fire) begin
                ck_rmt_q[ckt_q]  <= rmt_post;
                ck_head_q[ckt_q] <= head_d;
            end
        end
    end

    assign bus.ren_ready    = ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_rs_phys  = out_rs_q;
    assign bus.out_rt_phys  = out_rt_q;
    assign bus.out_rw_phys  = out_rw_q;
    assign bus.out_old_phys = out_old_q;
    assign bus.out_rs_busy  = out_rs_busy_q;
    assign bus.out_rt_busy  = out_rt_busy_q;
    assign bus.out_ckpt_id  = out_ckpt_q;
    assign bus.fl_count     = fl_cnt;
    assign bus.ckpt_count   = ckc_q;
endmodule

// File: doc/reg_rename_ckpt.md
REG_RENAME_CKPT -- requirements
Module: reg_rename_ckpt

Interface
REQ-001 Parameter NUM_ARCH_REGS, default 32, number of architectural registers; register 0 hardwired zero.
REQ-002 Parameter NUM_PHYS_REGS, default 64, physical register count; must be greater than NUM_ARCH_REGS and a power of two.
REQ-003 Parameter NUM_CKPT, default 4, branch checkpoint depth; power of two. AW = log2(NUM_ARCH_REGS), PW = log2(NUM_PHYS_REGS), CW = log2(NUM_CKPT).
REQ-004 Port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1, synchronous active-high reset.
REQ-006 ren_valid in 1, decode offers an instruction; ren_ready out 1, rename accepts it this cycle.
REQ-007 ren_rs, ren_rt in AW, source architectural registers; ren_rw in AW, destination; ren_uses_rw in 1, destination present; ren_is_branch in 1, instruction needs a checkpoint.
REQ-008 out_valid out 1, registered result valid; out_rs_phys, out_rt_phys, out_rw_phys out PW each; out_old_phys out PW, previous mapping of rw; out_rs_busy, out_rt_busy out 1 each; out_ckpt_id out CW.
REQ-009 wb_valid in 1, wb_phys in PW, writeback clears busy bit.
REQ-010 commit_valid in 1, commit_old_phys in PW, commit returns a stale register to the free list.
REQ-011 br_valid in 1, br_mispredict in 1, resolution of the oldest outstanding checkpoint.
REQ-012 fl_count out PW+1, current free-list occupancy; ckpt_count out CW+1, checkpoints in use.

Function
REQ-013 Accept (fire) when ren_valid and ren_ready are both high.
REQ-014 ren_ready = !(br_valid && br_mispredict) && (fl_count != 0 || !dest) && (ckpt_count != NUM_CKPT || !ren_is_branch); dest means ren_uses_rw with ren_rw != 0.
REQ-015 A write to ren_rw = 0 is treated as no destination: no allocation, out_rw_phys = 0, out_old_phys = 0.
REQ-016 Latency is one cycle: out_* reflect the fire of the previous cycle; out_valid is low in any cycle following a non-fire.
REQ-017 On fire with a destination: pop the free-list head into out_rw_phys, set RMT[ren_rw] to it, set its busy bit, and report out_old_phys = prior RMT[ren_rw].
REQ-018 Source lookups use the RMT before this fire's update, so rs == rw returns the old mapping.
REQ-019 out_rs_busy / out_rt_busy = busy bit of the looked-up tag, forced 0 if wb_valid targets that tag in the same cycle; physical register 0 is never busy.
REQ-020 The free list is a circular buffer of depth NUM_PHYS_REGS with (PW+1)-bit head and tail pointers; fl_count = tail - head; commit pushes at tail, allocation pops at head.
REQ-021 Commit of tag 0 is ignored. Commit and allocation in the same cycle are both performed; a register freed this cycle is not allocatable until the next cycle.
REQ-022 On fire with ren_is_branch: snapshot the post-rename RMT and the free-list head into checkpoint slot ckpt_tail; out_ckpt_id = that slot; ckpt_tail increments and wraps modulo NUM_CKPT.
REQ-023 Checkpoints resolve in order. br_valid without mispredict releases the oldest checkpoint (ckpt_head increments).
REQ-024 br_valid with mispredict does the following in one cycle: restore RMT and free-list head from the oldest checkpoint, discard all checkpoints (ckpt_count = 0), and suppress rename.
REQ-025 A commit in the same cycle as a mispredict still pushes at the tail.
REQ-026 Busy bits are not restored on a mispredict; reallocation sets them again.
REQ-027 br_valid with ckpt_count = 0 is ignored.
REQ-028 A writeback in the same cycle as an allocation of the same tag leaves the busy bit set; allocation wins.

Reset
REQ-029 While rst is high: RMT[i] = i; all busy bits 0; the free list holds NUM_ARCH_REGS..NUM_PHYS_REGS-1 in ascending order from head; fl_count = NUM_PHYS_REGS - NUM_ARCH_REGS; ckpt_count = 0.
REQ-030 While rst is high all out_* are 0 and ren_ready is 0. Reset mid-operation discards all in-flight state, and the first accept is possible on the cycle after rst falls.

Verification
REQ-031 Reset, then rename rw=5, rs=5 -> out_rw_phys=32, out_old_phys=5, out_rs_phys=5, out_rs_busy=0, fl_count 32->31.
REQ-032 Rename rw=3 twice, then rs=3 -> second gives old_phys=32; source gives phys 33 busy=1; wb 33 the same cycle -> busy=0.
REQ-033 32 destination renames with no commits -> fl_count=0, ren_ready low for dest and high for rw=0; commit 40 -> ready the next cycle, allocates 40.
REQ-034 Branch (ckpt 0), rename rw=7 and rw=8, then mispredict -> RMT[7]=7, RMT[8]=8, fl_count restored, ckpt_count=0, no fire in the mispredict cycle.
REQ-035 Rename 4 branches -> ckpt_count=4 and a fifth branch stalls; a correct resolve frees a slot and the fifth gets ckpt_id 0 (wrap).
REQ-036 Mispredict with commit of 50 in the same cycle -> 50 is present at the tail and fl_count = restored count + 1.
